xif_copro_commit_tracker: RTL and testbench

XIF_COPRO_COMMIT_TRACKER -- requirements
Module: xif_copro_commit_tracker

---
 rtl/xif_copro_pkg.sv | 16 +
 rtl/xif_copro_id_cam.sv | 23 ++
 rtl/xif_copro_commit_tracker.sv | 163 ++++++++++++++++
 tb/tb_xif_copro_commit_tracker.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xif_copro_pkg.sv
// Shared types and defaults for the XIF coprocessor commit tracker.
// Holds the per-entry status struct and the default tracker depth.
package xif_copro_pkg;

    localparam int TRACKER_DEPTH = 4;

    // Status bits of one in-flight entry.
    // The id and payload sit in parallel arrays in the tracker because their
    // widths are module parameters.
    typedef struct packed {
        logic valid;
        logic committed;
        logic killed;
    } trk_entry_t;

endpackage

// File: rtl/xif_copro_id_cam.sv
// Id CAM: compares a key against every stored id that is currently valid.
// Ports: valid (per-entry), ids (flattened), key -> match (one-hot), hit.
module xif_copro_id_cam #(
    parameter int DEPTH    = 4,
    parameter int ID_WIDTH = 4
) (
    input  logic [DEPTH-1:0]          valid,
    input  logic [DEPTH*ID_WIDTH-1:0] ids,
    input  logic [ID_WIDTH-1:0]       key,
    output logic [DEPTH-1:0]          match,
    output logic                      hit
);

    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = valid[i] && (ids[i*ID_WIDTH +: ID_WIDTH] == key);
        end
    end

    assign hit = |match;

endmodule

// File: rtl/xif_copro_commit_tracker.sv
// In-order tracker for offloaded XIF instructions awaiting commit/kill.
// Ports: issue push (valid/ready/id/data), commit (valid/id/kill),
// in-order release (valid/ready/id/data), count, unmatched-commit pulse.
module xif_copro_commit_tracker
    import xif_copro_pkg::*;
#(
    parameter int DEPTH         = TRACKER_DEPTH,
    parameter int ID_WIDTH      = 4,
    parameter int PAYLOAD_WIDTH = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         issue_valid_i,
    output logic                         issue_ready_o,
    input  logic [ID_WIDTH-1:0]          issue_id_i,
    input  logic [PAYLOAD_WIDTH-1:0]     issue_data_i,
    input  logic                         commit_valid_i,
    input  logic [ID_WIDTH-1:0]          commit_id_i,
    input  logic                         commit_kill_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [ID_WIDTH-1:0]          out_id_o,
    output logic [PAYLOAD_WIDTH-1:0]     out_data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         unmatched_commit_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    trk_entry_t                 st   [DEPTH];
    logic [ID_WIDTH-1:0]        ids  [DEPTH];
    logic [PAYLOAD_WIDTH-1:0]   data [DEPTH];

    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [CNT_W-1:0]           cnt;
    logic                       unmatched_q;

    logic [DEPTH-1:0]           vld_vec;
    logic [DEPTH*ID_WIDTH-1:0]  id_flat;
    logic [DEPTH-1:0]           cmt_match;
    logic [DEPTH-1:0]           iss_match;
    logic                       cmt_hit;
    logic                       iss_hit;

    trk_entry_t                 head;
    logic                       release_ok;
    logic                       drop;
    logic                       pop;
    logic                       push;
    logic                       cmt_new;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        vld_vec = '0;
        id_flat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            vld_vec[i]                          = st[i].valid;
            id_flat[i*ID_WIDTH +: ID_WIDTH]     = ids[i];
        end
    end

    xif_copro_id_cam #(
        .DEPTH    (DEPTH),
        .ID_WIDTH (ID_WIDTH)
    ) u_cmt_cam (
        .valid (vld_vec),
        .ids   (id_flat),
        .key   (commit_id_i),
        .match (cmt_match),
        .hit   (cmt_hit)
    );

    xif_copro_id_cam #(
        .DEPTH    (DEPTH),
        .ID_WIDTH (ID_WIDTH)
    ) u_iss_cam (
        .valid (vld_vec),
        .ids   (id_flat),
        .key   (issue_id_i),
        .match (iss_match),
        .hit   (iss_hit)
    );

    // Ready depends only on registered occupancy, so a same-cycle pop
    // never opens a slot early.
    assign issue_ready_o = (cnt < CNT_W'(DEPTH)) && !iss_hit;
    assign push          = issue_valid_i && issue_ready_o;

    // A push only succeeds when no valid entry holds its id, so a commit
    // to that id can hit either the old entries or the new one, never both.
    assign cmt_new = commit_valid_i && push && (issue_id_i == commit_id_i);

    assign head       = st[rd_ptr];
    assign release_ok = head.valid && head.committed && !head.killed;
    assign drop       = head.valid && head.killed;
    assign pop        = (release_ok && out_ready_i) || drop;

    assign out_valid_o        = release_ok;
    assign out_id_o           = release_ok ? ids[rd_ptr]  : '0;
    assign out_data_o         = release_ok ? data[rd_ptr] : '0;
    assign count_o            = cnt;
    assign unmatched_commit_o = unmatched_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                st[i] <= '0;
            end
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt         <= '0;
            unmatched_q <= 1'b0;
        end else begin
            unmatched_q <= commit_valid_i && !cmt_hit && !cmt_new;

            if (push) begin
                st[wr_ptr] <= '{valid:     1'b1,
                                committed: cmt_new && !commit_kill_i,
                                killed:    cmt_new && commit_kill_i};
                wr_ptr     <= ptr_inc(wr_ptr);
            end

            // First resolution wins: later commit/kill to a resolved entry
            // is dropped, so kill cannot override a commit.
            for (int i = 0; i < DEPTH; i++) begin
                if (commit_valid_i && cmt_match[i] &&
                    !st[i].committed && !st[i].killed) begin
                    if (commit_kill_i) begin
                        st[i].killed <= 1'b1;
                    end else begin
                        st[i].committed <= 1'b1;
                    end
                end
            end

            // Popped head is already resolved, so the loop above never
            // touches it in the same cycle.
            if (pop) begin
                st[rd_ptr] <= '0;
                rd_ptr     <= ptr_inc(rd_ptr);
            end

            unique case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            ids[wr_ptr]  <= issue_id_i;
            data[wr_ptr] <= issue_data_i;
        end
    end

endmodule

// File: tb/tb_xif_copro_commit_tracker.sv
// Self-checking bench for xif_copro_commit_tracker (DEPTH=4 and DEPTH=3).
// Released entries are checked against a scoreboard of expected {id,data}.
module tb_xif_copro_commit_tracker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [3:0] id);
        return {16'hC0DE, 12'h000, id, 28'h5A5A5A5, id};
    endfunction

    // ---------------- DEPTH=4 instance ----------------
    logic        rst4;
    logic        iv4, cv4, ck4, ordy4;
    logic [3:0]  iid4, cid4;
    logic [63:0] idat4;
    logic        irdy4, ovld4, unm4;
    logic [3:0]  oid4;
    logic [63:0] odat4;
    logic [2:0]  cnt4;

    xif_copro_commit_tracker #(
        .DEPTH(4), .ID_WIDTH(4), .PAYLOAD_WIDTH(64)
    ) dut4 (
        .clk_i(clk), .rst_i(rst4),
        .issue_valid_i(iv4), .issue_ready_o(irdy4),
        .issue_id_i(iid4), .issue_data_i(idat4),
        .commit_valid_i(cv4), .commit_id_i(cid4), .commit_kill_i(ck4),
        .out_valid_o(ovld4), .out_ready_i(ordy4),
        .out_id_o(oid4), .out_data_o(odat4),
        .count_o(cnt4), .unmatched_commit_o(unm4)
    );

    // ---------------- DEPTH=3 instance ----------------
    logic        rst3;
    logic        iv3, cv3, ck3, ordy3;
    logic [3:0]  iid3, cid3;
    logic [63:0] idat3;
    logic        irdy3, ovld3, unm3;
    logic [3:0]  oid3;
    logic [63:0] odat3;
    logic [1:0]  cnt3;

    xif_copro_commit_tracker #(
        .DEPTH(3), .ID_WIDTH(4), .PAYLOAD_WIDTH(64)
    ) dut3 (
        .clk_i(clk), .rst_i(rst3),
        .issue_valid_i(iv3), .issue_ready_o(irdy3),
        .issue_id_i(iid3), .issue_data_i(idat3),
        .commit_valid_i(cv3), .commit_id_i(cid3), .commit_kill_i(ck3),
        .out_valid_o(ovld3), .out_ready_i(ordy3),
        .out_id_o(oid3), .out_data_o(odat3),
        .count_o(cnt3), .unmatched_commit_o(unm3)
    );

    logic [67:0] exp4[$];
    logic [67:0] exp3[$];

    // Handshake observed mid-cycle completes on the next rising edge.
    always @(negedge clk) begin
        logic [67:0] e;
        if (!rst4) begin
            if (ovld4 && ordy4) begin
                if (exp4.size() == 0) begin
                    check("rel4_expected", 64'(exp4.size()), 64'd1);
                end else begin
                    e = exp4.pop_front();
                    check("rel4_id", 64'(oid4), 64'(e[67:64]));
                    check("rel4_data", odat4, e[63:0]);
                end
            end else if (!ovld4) begin
                check("idle4_zero", odat4 | 64'(oid4), 64'd0);
            end
        end
        if (!rst3) begin
            if (ovld3 && ordy3) begin
                if (exp3.size() == 0) begin
                    check("rel3_expected", 64'(exp3.size()), 64'd1);
                end else begin
                    e = exp3.pop_front();
                    check("rel3_id", 64'(oid3), 64'(e[67:64]));
                    check("rel3_data", odat3, e[63:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push4(input logic [3:0] id, input bit cmt,
                         input bit kill, input bit rel);
        iv4 = 1'b1; iid4 = id; idat4 = mk(id);
        cv4 = cmt;  cid4 = id; ck4 = kill;
        if (rel) exp4.push_back({id, mk(id)});
        tick();
        iv4 = 1'b0; cv4 = 1'b0; ck4 = 1'b0;
    endtask

    task automatic cmt4(input logic [3:0] id, input bit kill);
        cv4 = 1'b1; cid4 = id; ck4 = kill;
        tick();
        cv4 = 1'b0; ck4 = 1'b0;
    endtask

    task automatic push3(input logic [3:0] id, input bit cmt, input bit rel);
        iv3 = 1'b1; iid3 = id; idat3 = mk(id);
        cv3 = cmt;  cid3 = id; ck3 = 1'b0;
        if (rel) exp3.push_back({id, mk(id)});
        tick();
        iv3 = 1'b0; cv3 = 1'b0;
    endtask

    initial begin
        logic [3:0] a;
        rst4 = 1'b1; rst3 = 1'b1;
        iv4 = 0; cv4 = 0; ck4 = 0; ordy4 = 0; iid4 = 0; cid4 = 0; idat4 = 0;
        iv3 = 0; cv3 = 0; ck3 = 0; ordy3 = 0; iid3 = 0; cid3 = 0; idat3 = 0;
        tick(); tick();
        rst4 = 1'b0; rst3 = 1'b0;

        check("rst_count", 64'(cnt4), 64'd0);
        check("rst_ovalid", 64'(ovld4), 64'd0);
        check("rst_ready", 64'(irdy4), 64'd1);
        check("rst_unmatched", 64'(unm4), 64'd0);

        // Out-of-order commit, in-order release.
        push4(4'd1, 0, 0, 1);
        push4(4'd2, 0, 0, 1);
        push4(4'd3, 0, 0, 1);
        check("ooo_count", 64'(cnt4), 64'd3);
        cmt4(4'd2, 0);
        cmt4(4'd3, 0);
        check("ooo_blocked", 64'(ovld4), 64'd0);
        cmt4(4'd1, 0);
        check("ooo_first_valid", 64'(ovld4), 64'd1);
        check("ooo_first_id", 64'(oid4), 64'd1);
        ordy4 = 1'b1;
        tick(); tick(); tick();
        check("ooo_drained", 64'(cnt4), 64'd0);

        // Full tracker back-pressure.
        for (int i = 0; i < 4; i++) push4(4'(i), 0, 0, 1);
        iid4 = 4'd4;
        check("full_ready", 64'(irdy4), 64'd0);
        check("full_count", 64'(cnt4), 64'd4);
        cmt4(4'd0, 0);
        iv4 = 1'b1; iid4 = 4'd4; idat4 = mk(4'd4);
        check("pop_no_early_ready", 64'(irdy4), 64'd0);
        tick();
        check("after_pop_count", 64'(cnt4), 64'd3);
        check("after_pop_ready", 64'(irdy4), 64'd1);
        exp4.push_back({4'd4, mk(4'd4)});
        tick();
        iv4 = 1'b0;
        check("id4_accepted", 64'(cnt4), 64'd4);
        iid4 = 4'd1;
        check("dup_id_ready", 64'(irdy4), 64'd0);
        for (int i = 1; i <= 4; i++) cmt4(4'(i), 0);
        tick(); tick();
        check("full_drained", 64'(cnt4), 64'd0);

        // Killed entries dropped without output.
        push4(4'd5, 0, 0, 0);
        push4(4'd6, 0, 0, 0);
        push4(4'd7, 0, 0, 1);
        cmt4(4'd5, 1);
        check("kill_cnt_a", 64'(cnt4), 64'd3);
        cmt4(4'd6, 1);
        check("kill_cnt_b", 64'(cnt4), 64'd2);
        cmt4(4'd7, 0);
        check("kill_cnt_c", 64'(cnt4), 64'd1);
        check("kill_out_id", 64'(oid4), 64'd7);
        tick();
        check("kill_cnt_zero", 64'(cnt4), 64'd0);

        // Same-cycle push+commit, then unmatched commit.
        ordy4 = 1'b0;
        push4(4'd9, 1, 0, 1);
        check("same_cyc_valid", 64'(ovld4), 64'd1);
        check("same_cyc_id", 64'(oid4), 64'd9);
        cmt4(4'd12, 0);
        check("unmatched_pulse", 64'(unm4), 64'd1);
        check("unmatched_count", 64'(cnt4), 64'd1);
        check("unmatched_head", 64'(oid4), 64'd9);
        tick();
        check("unmatched_clear", 64'(unm4), 64'd0);

        // Stalled head stays stable.
        for (int i = 0; i < 5; i++) begin
            check("stall_id", 64'(oid4), 64'd9);
            check("stall_data", odat4, mk(4'd9));
            tick();
        end
        ordy4 = 1'b1;
        tick();
        ordy4 = 1'b0;
        check("stall_single_pop", 64'(cnt4), 64'd0);
        check("stall_no_valid", 64'(ovld4), 64'd0);

        // Kill after commit is ignored.
        push4(4'd10, 1, 0, 1);
        cmt4(4'd10, 1);
        check("kill_after_cmt", 64'(ovld4), 64'd1);
        check("kill_after_unm", 64'(unm4), 64'd0);
        ordy4 = 1'b1;
        tick();
        check("kill_after_pop", 64'(cnt4), 64'd0);

        // DEPTH=3 wrap-around rounds.
        ordy3 = 1'b1;
        for (int r = 0; r < 10; r++) begin
            a = 4'(2 * r);
            push3(a, 1, 1);
            push3(a + 4'd1, 0, 1);
            cv3 = 1'b1; cid3 = a + 4'd1;
            tick();
            cv3 = 1'b0;
        end
        tick(); tick();
        check("d3_drained", 64'(cnt3), 64'd0);
        check("d3_all_released", 64'(exp3.size()), 64'd0);

        // Reset mid-stream with committed entries pending.
        ordy3 = 1'b0;
        push3(4'd1, 1, 0);
        push3(4'd2, 1, 0);
        push3(4'd3, 0, 0);
        check("d3_full", 64'(cnt3), 64'd3);
        check("d3_full_ready", 64'(irdy3), 64'd0);
        rst3 = 1'b1;
        cv3 = 1'b1; cid3 = 4'd3;
        tick();
        rst3 = 1'b0; cv3 = 1'b0;
        check("d3_rst_count", 64'(cnt3), 64'd0);
        check("d3_rst_valid", 64'(ovld3), 64'd0);
        check("d3_rst_ready", 64'(irdy3), 64'd1);
        check("d3_rst_unm", 64'(unm3), 64'd0);
        ordy3 = 1'b1;
        tick(); tick(); tick(); tick();
        check("d3_no_stale", 64'(ovld3), 64'd0);
        check("d3_post_count", 64'(cnt3), 64'd0);

        check("d4_all_released", 64'(exp4.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
